iobus_uart: RTL

Memory-mapped 8N1 UART peripheral with TX and RX FIFOs, attached to the IO bus as a slave behind `iobus_top` decode. It is a second serial channel alongside the MCS-internal UART. It drives one external interrupt line into the MCS `INTC_Interrupt` vector. The baud rate is set at runtime through a divisor register; there is no dependency on the MCS UART configuration.

---
 rtl/iobus_uart.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/iobus_uart.sv
// Memory-mapped 8N1 UART slave for the IO bus: TX/RX FIFOs, runtime baud divisor,
// W1C error flags and a registered level interrupt.
module iobus_uart #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_RESET  = 433
) (
    input  logic        io_clk,
    input  logic        io_rst,
    input  logic        io_sel,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [1:0]  io_address,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   DIV_MIN  = 16'd7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

    // Bus-side registers
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        rxie_q, txie_q;
    logic [15:0] div_q;
    logic        rxovr_q, ferr_q, txovf_q;
    logic        irq_q;

    // FIFOs
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q;

    // Serial engines
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_bcnt_q, tx_bcnt_d, tx_per_q, tx_per_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_pop;

    rx_state_e   rx_state_q, rx_state_d;
    logic [1:0]  rx_sync_q;
    logic [15:0] rx_bcnt_q, rx_bcnt_d, rx_per_q, rx_per_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_push_req, ferr_set;

    logic        acc_rd, acc_wr;
    logic        tx_wr_req, tx_push, txovf_set;
    logic        rx_pop, rx_push, rxovr_set;
    logic        tx_empty, tx_full, rx_empty, rx_full, tx_busy;
    logic        ctrl_we, w1c_we;
    logic [1:0]  div_we;
    logic [7:0]  status;
    logic [31:0] rd_mux;
    logic [15:0] div_eff;
    logic        tx_tick, rx_tick, rx_s;
    logic [16:0] rx_half;
    logic [15:0] rx_mid;
    logic        unused_ok;

    assign acc_rd = io_sel & io_read_strobe;
    assign acc_wr = io_sel & io_write_strobe;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign tx_busy  = (tx_state_q != TX_IDLE) | ~tx_empty;

    // A full FIFO still accepts a push when the other side pops in the same cycle
    assign tx_wr_req = acc_wr & (io_address == 2'd0) & io_byte_enable[0];
    assign tx_push   = tx_wr_req & (~tx_full | tx_pop);
    assign txovf_set = tx_wr_req & tx_full & ~tx_pop;
    assign rx_pop    = acc_rd & (io_address == 2'd0) & ~rx_empty;
    assign rx_push   = rx_push_req & (~rx_full | rx_pop);
    assign rxovr_set = rx_push_req & rx_full & ~rx_pop;

    assign ctrl_we = acc_wr & (io_address == 2'd2) & io_byte_enable[0];
    assign w1c_we  = acc_wr & (io_address == 2'd1) & io_byte_enable[0];
    assign div_we  = {2{acc_wr & (io_address == 2'd3)}} & io_byte_enable[1:0];

    assign status  = {tx_busy, txovf_q, ferr_q, rxovr_q, tx_full, tx_empty, rx_full, ~rx_empty};
    assign div_eff = (div_q < DIV_MIN) ? DIV_MIN : div_q;

    assign unused_ok = ^{io_write_data[31:16], io_byte_enable[3:2]};

    always_comb begin
        rd_mux = '0;
        case (io_address)
            2'd0:    rd_mux = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rptr_q]};
            2'd1:    rd_mux = {24'h0, status};
            2'd2:    rd_mux = {30'h0, txie_q, rxie_q};
            default: rd_mux = {16'h0, div_q};
        endcase
    end

    // Bus response, control/divisor registers, sticky flags and interrupt
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            rxie_q  <= 1'b0;
            txie_q  <= 1'b0;
            div_q   <= 16'(DIV_RESET);
            rxovr_q <= 1'b0;
            ferr_q  <= 1'b0;
            txovf_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ready_q <= acc_rd | acc_wr;
            rdata_q <= acc_rd ? rd_mux : 32'h0;
            if (ctrl_we) begin
                rxie_q <= io_write_data[0];
                txie_q <= io_write_data[1];
            end
            if (div_we[0]) div_q[7:0]  <= io_write_data[7:0];
            if (div_we[1]) div_q[15:8] <= io_write_data[15:8];
            rxovr_q <= rxovr_set | (rxovr_q & ~(w1c_we & io_write_data[4]));
            ferr_q  <= ferr_set  | (ferr_q  & ~(w1c_we & io_write_data[5]));
            txovf_q <= txovf_set | (txovf_q & ~(w1c_we & io_write_data[6]));
            irq_q   <= (rxie_q & ~rx_empty) | (txie_q & tx_empty);
        end
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PW'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PW'(1);
            if (rx_push) rx_wptr_q <= rx_wptr_q + PW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PW'(1);
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
            rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge io_clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= io_write_data[7:0];
        if (rx_push) rx_mem[rx_wptr_q] <= rx_shift_q;
    end

    // Transmitter: the bit period is relatched at every bit boundary
    assign tx_tick = (tx_bcnt_q == tx_per_q);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bcnt_d  = tx_bcnt_q + 16'd1;
        tx_per_d   = tx_per_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_bcnt_d = '0;
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_mem[tx_rptr_q];
                    tx_per_d   = div_eff;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_bcnt_d  = '0;
                    tx_per_d   = div_eff;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_bcnt_d = '0;
                    tx_per_d  = div_eff;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end
            end
            default: begin
                if (tx_tick) begin
                    tx_bcnt_d = '0;
                    tx_per_d  = div_eff;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_mem[tx_rptr_q];
                        tx_line_d  = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            tx_state_q <= TX_IDLE;
            tx_bcnt_q  <= '0;
            tx_per_q   <= DIV_MIN;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_per_q   <= tx_per_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // Receiver: start bit is rechecked at half period, data sampled mid-bit
    assign rx_s    = rx_sync_q[1];
    assign rx_tick = (rx_bcnt_q == rx_per_q);
    assign rx_half = ({1'b0, rx_per_q} + 17'd1) >> 1;
    assign rx_mid  = 16'(rx_half - 17'd1);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_bcnt_d   = rx_bcnt_q + 16'd1;
        rx_per_d    = rx_per_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_bcnt_d = '0;
                if (!rx_s) begin
                    rx_per_d   = div_eff;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_bcnt_q == rx_mid) begin
                    rx_bcnt_d = '0;
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bit_d   = '0;
                        rx_per_d   = div_eff;
                        rx_state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_bcnt_d  = '0;
                    rx_per_d   = div_eff;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_bcnt_d = '0;
                    if (!rx_s) begin
                        ferr_set   = 1'b1;
                        rx_state_d = RX_BREAK;
                    end else begin
                        rx_push_req = 1'b1;
                        rx_state_d  = RX_IDLE;
                    end
                end
            end
            RX_BREAK: begin
                rx_bcnt_d = '0;
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: begin
                rx_bcnt_d  = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_bcnt_q  <= '0;
            rx_per_q   <= DIV_MIN;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_state_q <= rx_state_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_per_q   <= rx_per_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    assign io_ready     = ready_q;
    assign io_read_data = rdata_q;
    assign uart_tx      = tx_line_q;
    assign irq          = irq_q;

endmodule
